// File: rtl/alu_mdu_pkg.sv
// rtl/alu_mdu_pkg.sv - op codes, FSM states and op-class helpers for alu_mdu
package alu_mdu_pkg;

    // MUL/DIV codes sit in the top quarter: bit1 selects divide, bit0 selects unsigned.
    typedef enum logic [3:0] {
        EXE_ALU_ADD   = 4'd0,
        EXE_ALU_SUB   = 4'd1,
        EXE_ALU_SLT   = 4'd2,
        EXE_ALU_SLTU  = 4'd3,
        EXE_ALU_AND   = 4'd4,
        EXE_ALU_OR    = 4'd5,
        EXE_ALU_XOR   = 4'd6,
        EXE_ALU_NOR   = 4'd7,
        EXE_ALU_LUI   = 4'd8,
        EXE_ALU_SLL   = 4'd9,
        EXE_ALU_SRL   = 4'd10,
        EXE_ALU_SRA   = 4'd11,
        EXE_ALU_MULT  = 4'd12,
        EXE_ALU_MULTU = 4'd13,
        EXE_ALU_DIV   = 4'd14,
        EXE_ALU_DIVU  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic is_mdu_op(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative shift-add multiply / restoring divide on operand magnitudes
module mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             sgn_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    logic             run_q, div_q, neg_q, neg_rem_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] acc_q, mq_q, den_q;

    logic [WIDTH-1:0]   a_mag, b_mag, mul_add, div_diff;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign a_mag     = (sgn_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag     = (sgn_i && b_i[WIDTH-1]) ? -b_i : b_i;
    assign mul_add   = mq_q[0] ? den_q : '0;
    assign mul_sum   = {1'b0, acc_q} + {1'b0, mul_add};
    assign div_shift = {acc_q, mq_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, den_q};
    assign div_diff  = div_shift[WIDTH-1:0] - den_q;

    // done_o flags the final iteration; hi_o/lo_o are final on the following cycle.
    assign done_o = run_q && (cnt_q == CNT_LAST);

    assign prod     = {acc_q, mq_q};
    assign prod_neg = -prod;
    assign hi_o = div_q ? (neg_rem_q ? -acc_q : acc_q) : (neg_q ? prod_neg[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH]);
    assign lo_o = div_q ? (neg_q ? -mq_q : mq_q) : (neg_q ? prod_neg[WIDTH-1:0] : prod[WIDTH-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            den_q     <= '0;
        end else if (abort_i) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_i) begin
            run_q     <= 1'b1;
            cnt_q     <= '0;
            div_q     <= is_div_i;
            // Divide by zero keeps the all-ones quotient unsigned; remainder regains a's sign.
            neg_q     <= sgn_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]) && !(is_div_i && (b_i == '0));
            neg_rem_q <= sgn_i && is_div_i && a_i[WIDTH-1];
            acc_q     <= '0;
            mq_q      <= a_mag;
            den_q     <= b_mag;
        end else if (run_q) begin
            cnt_q <= cnt_q + CNT_ONE;
            if (done_o) begin
                run_q <= 1'b0;
            end
            if (div_q) begin
                acc_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                mq_q  <= {mq_q[WIDTH-2:0], div_ge};
            end else begin
                acc_q <= mul_sum[WIDTH:1];
                mq_q  <= {mul_sum[0], mq_q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - EXE-stage ALU with iterative MUL/DIV, handshake FSM and registered outputs
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       oper,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ovf,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;

    logic             accept, start_mdu, mdu_done, alu_ovf;
    logic [WIDTH-1:0] mdu_hi, mdu_lo, alu_res, sum, diff;
    logic [SHW-1:0]   shamt;

    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign start_mdu = accept && is_mdu_op(oper);
    assign sum       = a + b;
    assign diff      = a - b;
    assign shamt     = a[SHW-1:0];

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign ovf       = ovf_q;
    assign busy      = state_q != ST_IDLE;

    mdu_iter #(.WIDTH(WIDTH)) u_mdu_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_mdu),
        .abort_i  (flush),
        .sgn_i    (~oper[0]),
        .is_div_i (oper[1]),
        .a_i      (a),
        .b_i      (b),
        .done_o   (mdu_done),
        .hi_o     (mdu_hi),
        .lo_o     (mdu_lo)
    );

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (oper)
            EXE_ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            EXE_ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            EXE_ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            EXE_ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            EXE_ALU_AND:  alu_res = a & b;
            EXE_ALU_OR:   alu_res = a | b;
            EXE_ALU_XOR:  alu_res = a ^ b;
            EXE_ALU_NOR:  alu_res = ~(a | b);
            EXE_ALU_LUI:  alu_res = b << (WIDTH / 2);
            EXE_ALU_SLL:  alu_res = b << shamt;
            EXE_ALU_SRL:  alu_res = b >> shamt;
            EXE_ALU_SRA:  alu_res = $signed(b) >>> shamt;
            default:      alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        ovf_d       = ovf_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_mdu) begin
                        state_d = ST_ITER;
                    end else if (accept) begin
                        result_d    = alu_res;
                        ovf_d       = alu_ovf;
                        out_valid_d = 1'b1;
                    end
                end
                ST_ITER: begin
                    if (mdu_done) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_d        = mdu_hi;
                    lo_d        = mdu_lo;
                    result_d    = mdu_lo;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - randomized and directed self-checking bench for alu_mdu against an arithmetic model
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [3:0]    oper = '0;
    logic          in_ready, out_valid, ovf, busy;
    logic [W-1:0]  result, hi, lo;

    alu_mdu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .oper      (oper),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .hi        (hi),
        .lo        (lo),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          due;
        logic        mdu;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the op's meaning, committed HI/LO passed through.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] chi, input logic [31:0] clo);
        exp_t        e;
        longint      sx, sy, s, qq, rr;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e = '0;
        e.hi = chi;
        e.lo = clo;
        e.mdu = (op >= 4'd12);
        case (op)
            4'd0: begin s = sx + sy; e.res = s[31:0]; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd1: begin s = sx - sy; e.res = s[31:0]; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd2: e.res = (sx < sy) ? 32'd1 : 32'd0;
            4'd3: e.res = (x < y) ? 32'd1 : 32'd0;
            4'd4: e.res = x & y;
            4'd5: e.res = x | y;
            4'd6: e.res = x ^ y;
            4'd7: e.res = ~(x | y);
            4'd8: e.res = y * 32'd65536;
            4'd9: e.res = y << x[4:0];
            4'd10: e.res = y >> x[4:0];
            4'd11: begin s = sy >>> x[4:0]; e.res = s[31:0]; end
            4'd12: begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
            4'd13: begin p = {32'd0, x} * {32'd0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
            4'd14: begin
                if (y == 0) begin e.lo = 32'hFFFFFFFF; e.hi = x; end
                else begin qq = sx / sy; rr = sx % sy; e.lo = qq[31:0]; e.hi = rr[31:0]; end
            end
            default: begin
                if (y == 0) begin e.lo = 32'hFFFFFFFF; e.hi = x; end
                else begin e.lo = x / y; e.hi = x % y; end
            end
        endcase
        if (e.mdu) e.res = e.lo;
        return e;
    endfunction

    always @(posedge clk) begin : model_step
        exp_t e;
        bit   ev, rdy;
        if (!rst_n) begin
            q.delete();
            m_hi = '0;
            m_lo = '0;
        end else begin
            ev  = (q.size() > 0) && (cyc >= q[0].due);
            rdy = !((q.size() > 0) && !ev) && (!ev || out_ready);
            if (ev && q[0].mdu) begin
                m_hi = q[0].hi;
                m_lo = q[0].lo;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (ev && out_ready) void'(q.pop_front());
                if (in_valid && rdy) begin
                    e = model(oper, a, b, m_hi, m_lo);
                    e.due = e.mdu ? cyc + 1 + W + 1 : cyc + 1;
                    q.push_back(e);
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin : compare
        bit ev, rdy, bsy;
        if (rst_n) begin
            ev  = (q.size() > 0) && (cyc >= q[0].due);
            bsy = (q.size() > 0) && !ev;
            rdy = !bsy && (!ev || out_ready);
            chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
            chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
            chk("busy", {31'd0, busy}, {31'd0, bsy});
            chk("hi", hi, ev ? q[0].hi : m_hi);
            chk("lo", lo, ev ? q[0].lo : m_lo);
            if (ev) begin
                chk("result", result, q[0].res);
                chk("ovf", {31'd0, ovf}, {31'd0, q[0].ovf});
            end
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output logic [31:0] h, output logic [31:0] l,
                          output logic o, output int lat);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; oper = op; a = x; b = y; out_ready = 1'b1;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        r = result; h = hi; l = lo; o = ovf;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_hi"}, hi, 32'd0);
        chk({tag, "_lo"}, lo, 32'd0);
        chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return $urandom_range(0, 15);
            default: return $urandom();
        endcase
    endfunction

    initial begin : stim
        logic [31:0] r, h, l;
        logic        o;
        int          lat, seen;
        exp_t        pin;

        pin = model(4'(EXE_ALU_MULT), 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0);
        chk("model_mult_hi", pin.hi, 32'hFFFFFFFF);
        chk("model_mult_lo", pin.lo, 32'hFFFFFFF1);
        pin = model(4'(EXE_ALU_DIV), 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0);
        chk("model_divmin_lo", pin.lo, 32'h80000000);
        chk("model_divmin_hi", pin.hi, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        run_op(EXE_ALU_ADD, 32'h7FFFFFFF, 32'd1, r, h, l, o, lat);
        chk("add_ovf_res", r, 32'h80000000);
        chk("add_ovf_flag", {31'd0, o}, 32'd1);
        chk("add_latency", lat, 32'd1);
        run_op(EXE_ALU_SLT, 32'hFFFFFFFF, 32'd1, r, h, l, o, lat);
        chk("slt", r, 32'd1);
        run_op(EXE_ALU_SLTU, 32'hFFFFFFFF, 32'd1, r, h, l, o, lat);
        chk("sltu", r, 32'd0);
        run_op(EXE_ALU_MULT, 32'hFFFFFFFD, 32'd5, r, h, l, o, lat);
        chk("mult_latency", lat, W + 2);
        chk("mult_hi", h, 32'hFFFFFFFF);
        chk("mult_lo", l, 32'hFFFFFFF1);
        chk("mult_result", r, 32'hFFFFFFF1);
        run_op(EXE_ALU_DIV, 32'hFFFFFFF9, 32'd2, r, h, l, o, lat);
        chk("div_lo", l, 32'hFFFFFFFD);
        chk("div_hi", h, 32'hFFFFFFFF);
        run_op(EXE_ALU_DIVU, 32'd7, 32'd0, r, h, l, o, lat);
        chk("divu0_lo", l, 32'hFFFFFFFF);
        chk("divu0_hi", h, 32'd7);
        chk("divu0_latency", lat, W + 2);
        run_op(EXE_ALU_SRA, 32'h24, 32'h80000000, r, h, l, o, lat);
        chk("sra", r, 32'hF8000000);
        run_op(EXE_ALU_LUI, 32'd0, 32'h1234, r, h, l, o, lat);
        chk("lui", r, 32'h12340000);

        @(posedge clk); #1;
        in_valid = 1'b1; oper = EXE_ALU_ADD; a = 32'd5; b = 32'd6; out_ready = 1'b0;
        @(posedge clk); #1;
        a = 32'd1; b = 32'd2;
        for (int i = 0; i < 5; i++) begin
            chk("hold_result", result, 32'd11);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            a = i; b = 32'd100;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        in_valid = 1'b1; oper = EXE_ALU_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_hi", hi, 32'd7);
        chk("flush_lo", lo, 32'hFFFFFFFF);
        seen = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("flush_no_valid", seen, 32'd0);

        in_valid = 1'b1; oper = EXE_ALU_MULT; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            oper      = 4'($urandom_range(0, 15));
            a         = rnd_operand();
            b         = rnd_operand();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (W + 8) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #400000;
        fails++;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
